// File: rtl/teclado_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package teclado_pkg;
  typedef enum logic [1:0] {SCAN, CONFIRM, REPORT, RELEASE} estado_e;

  localparam int NUM_FILAS = 4;
  localparam int NUM_COLS  = 4;
  localparam int CODE_W    = 4;

  localparam logic [NUM_COLS-1:0] COL_IDLE = 4'b1110;
endpackage

// File: rtl/anillo_columnas.sv
// Window counter plus one-hot active-low column ring; the ring steps once per
// window at the sample strobe unless frozen.
module anillo_columnas
  import teclado_pkg::*;
#(
  parameter int SCAN_DIV = 1000
) (
  input  logic                i_Clk,
  input  logic                i_Reset,
  input  logic                i_Congelar,
  output logic [NUM_COLS-1:0] o_Columnas,
  output logic [1:0]          o_Col_Idx,
  output logic                o_Muestra
);
  localparam int CW = $clog2(SCAN_DIV);

  logic [CW-1:0]       cnt_q, cnt_d;
  logic [NUM_COLS-1:0] ring_q, ring_d;

  always_ff @(posedge i_Clk or negedge i_Reset) begin
    if (!i_Reset) begin
      cnt_q  <= '0;
      ring_q <= COL_IDLE;
    end else begin
      cnt_q  <= cnt_d;
      ring_q <= ring_d;
    end
  end

  always_comb begin
    o_Muestra = (cnt_q == CW'(SCAN_DIV - 1));
    cnt_d     = o_Muestra ? '0 : cnt_q + CW'(1);
    ring_d    = (o_Muestra && !i_Congelar) ? {ring_q[NUM_COLS-2:0], ring_q[NUM_COLS-1]} : ring_q;
  end

  always_comb begin
    case (ring_q)
      4'b1101: o_Col_Idx = 2'd1;
      4'b1011: o_Col_Idx = 2'd2;
      4'b0111: o_Col_Idx = 2'd3;
      default: o_Col_Idx = 2'd0;
    endcase
  end

  assign o_Columnas = ring_q;
endmodule

// File: rtl/escaner_teclado.sv
// 4x4 keypad scanner: synchronizes rows, debounces one key at a time and hands
// the key code to the consumer through a valid/ack handshake.
module escaner_teclado
  import teclado_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_COUNT = 3
) (
  input  logic                 i_Clk,
  input  logic                 i_Reset,
  input  logic [NUM_FILAS-1:0] i_Filas,
  output logic [NUM_COLS-1:0]  o_Columnas,
  output logic [CODE_W-1:0]    o_Tecla,
  output logic                 o_Valido,
  input  logic                 i_Ack
);
  localparam int DW = $clog2(DEBOUNCE_COUNT + 1);

  logic [NUM_FILAS-1:0] sync1_q, sync2_q;
  estado_e              estado_q, estado_d;
  logic [DW-1:0]        deb_q, deb_d, deb_inc;
  logic [CODE_W-1:0]    code_q, code_d;
  logic [1:0]           col_idx, fila;
  logic [CODE_W-1:0]    cand;
  logic                 hit, muestra, avanzar;

  anillo_columnas #(.SCAN_DIV(SCAN_DIV)) u_anillo (
    .i_Clk      (i_Clk),
    .i_Reset    (i_Reset),
    .i_Congelar (!avanzar),
    .o_Columnas (o_Columnas),
    .o_Col_Idx  (col_idx),
    .o_Muestra  (muestra)
  );

  always_ff @(posedge i_Clk or negedge i_Reset) begin
    if (!i_Reset) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= i_Filas;
      sync2_q <= sync1_q;
    end
  end

  // Lowest-numbered low row wins when several keys share the column.
  always_comb begin
    fila = 2'd0;
    for (int i = NUM_FILAS - 1; i >= 0; i--)
      if (!sync2_q[i]) fila = 2'(i);
  end

  assign hit     = ~&sync2_q;
  assign cand    = {col_idx, fila};
  assign deb_inc = deb_q + DW'(1);

  always_ff @(posedge i_Clk or negedge i_Reset) begin
    if (!i_Reset) begin
      estado_q <= SCAN;
      deb_q    <= '0;
      code_q   <= '0;
    end else begin
      estado_q <= estado_d;
      deb_q    <= deb_d;
      code_q   <= code_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    deb_d    = deb_q;
    code_d   = code_q;
    avanzar  = 1'b0;
    case (estado_q)
      SCAN: if (muestra) begin
        if (hit) begin
          code_d   = cand;
          deb_d    = DW'(1);
          estado_d = (DEBOUNCE_COUNT == 1) ? REPORT : CONFIRM;
        end else begin
          avanzar = 1'b1;
        end
      end
      CONFIRM: if (muestra) begin
        if (hit && cand == code_q) begin
          deb_d = deb_inc;
          if (deb_inc == DW'(DEBOUNCE_COUNT)) estado_d = REPORT;
        end else begin
          deb_d    = '0;
          avanzar  = 1'b1;
          estado_d = SCAN;
        end
      end
      // Code is held here until taken; a release meanwhile is irrelevant.
      REPORT: if (i_Ack) begin
        deb_d    = '0;
        estado_d = RELEASE;
      end
      RELEASE: if (muestra) begin
        if (hit) begin
          deb_d = '0;
        end else if (deb_inc == DW'(DEBOUNCE_COUNT)) begin
          deb_d    = '0;
          avanzar  = 1'b1;
          estado_d = SCAN;
        end else begin
          deb_d = deb_inc;
        end
      end
      default: estado_d = SCAN;
    endcase
  end

  always_comb begin
    o_Valido = (estado_q == REPORT);
    o_Tecla  = code_q;
  end
endmodule

// File: tb/tb_escaner_teclado.sv
// Directed bench for escaner_teclado with a behavioural 4x4 keypad model.
module tb_escaner_teclado;
  logic       clk;
  logic       rst_n;
  logic [3:0] filas, filas_m, ovr;
  logic       ovr_en;
  logic [3:0] cols, tecla;
  logic       valido, ack;

  logic       k0_on, k1_on;
  logic [3:0] k0, k1;

  int n_chk  = 0;
  int n_fail = 0;
  int rises  = 0;
  logic v_prev = 1'b0;
  int n, snap;

  escaner_teclado #(.SCAN_DIV(4), .DEBOUNCE_COUNT(3)) dut (
    .i_Clk      (clk),
    .i_Reset    (rst_n),
    .i_Filas    (filas),
    .o_Columnas (cols),
    .o_Tecla    (tecla),
    .o_Valido   (valido),
    .i_Ack      (ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad: a pressed key pulls its row low only while its column is driven.
  always_comb begin
    filas_m = 4'hF;
    if (k0_on && !cols[k0[3:2]]) filas_m[k0[1:0]] = 1'b0;
    if (k1_on && !cols[k1[3:2]]) filas_m[k1[1:0]] = 1'b0;
  end
  assign filas = ovr_en ? ovr : filas_m;

  always @(negedge clk) begin
    if (valido && !v_prev) rises <= rises + 1;
    v_prev <= valido;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int maxc, output int cnt);
    cnt = 0;
    while (!valido && cnt < maxc) begin
      tick();
      cnt++;
    end
  endtask

  task automatic wait_cols_leave(input logic [3:0] from, input int maxc, output int cnt);
    cnt = 0;
    while (cols === from && cnt < maxc) begin
      tick();
      cnt++;
    end
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; ack = 1'b0;
    ovr_en = 1'b1; ovr = 4'b0000;
    k0_on = 1'b0; k1_on = 1'b0; k0 = 4'd0; k1 = 4'd0;

    // 1. reset state with rows all low, then idle ring rotation
    repeat (3) tick();
    chk("rst_cols", cols, 4'b1110);
    chk("rst_valid", valido, 1'b0);
    chk("rst_tecla", tecla, 4'd0);
    ovr_en = 1'b0;
    #2 rst_n = 1'b1;
    repeat (3) tick();
    chk("ring_hold", cols, 4'b1110);
    tick();
    chk("ring_c1", cols, 4'b1101);
    repeat (4) tick();
    chk("ring_c2", cols, 4'b1011);
    repeat (4) tick();
    chk("ring_c3", cols, 4'b0111);
    repeat (4) tick();
    chk("ring_wrap", cols, 4'b1110);

    // 2. clean press column 2 row 1
    snap = rises;
    k0 = 4'd9; k0_on = 1'b1;
    wait_valid(60, n);
    chk("p2_valid", valido, 1'b1);
    chk("p2_latency", n, 20);
    chk("p2_tecla", tecla, 4'd9);
    chk("p2_cols", cols, 4'b1011);
    repeat (7) tick();
    chk("p2_hold_valid", valido, 1'b1);
    pulse_ack();
    chk("p2_ack_drop", valido, 1'b0);
    repeat (20) tick();
    chk("p2_frozen", cols, 4'b1011);
    chk("p2_no_repeat", rises - snap, 1);
    k0_on = 1'b0;
    wait_cols_leave(4'b1011, 40, n);
    chk("p2_resume_cols", cols, 4'b0111);
    chk("p2_release_min", (n >= 11) ? 1 : 0, 1);
    chk("p2_release_max", (n <= 14) ? 1 : 0, 1);

    // 3. bouncing key column 0 row 3 (ack held high to show it is ignored)
    snap = rises;
    k0 = 4'd3;
    ack = 1'b1;
    for (int w = 0; w < 16; w++) begin
      k0_on = w[0];
      repeat (4) tick();
    end
    chk("p3_bounce_none", rises - snap, 0);
    chk("p3_bounce_valid", valido, 1'b0);
    ack = 1'b0;
    k0_on = 1'b1;
    wait_valid(80, n);
    chk("p3_valid", valido, 1'b1);
    chk("p3_tecla", tecla, 4'd3);
    pulse_ack();
    repeat (40) tick();
    chk("p3_once", rises - snap, 1);
    k0_on = 1'b0;
    repeat (30) tick();

    // 4. release before ack on column 3 row 0
    snap = rises;
    k0 = 4'd12; k0_on = 1'b1;
    wait_valid(80, n);
    chk("p4_valid", valido, 1'b1);
    k0_on = 1'b0;
    repeat (30) tick();
    chk("p4_kept_valid", valido, 1'b1);
    chk("p4_tecla", tecla, 4'd12);
    pulse_ack();
    chk("p4_ack_drop", valido, 1'b0);
    repeat (40) tick();
    chk("p4_once", rises - snap, 1);

    // 5. two keys on column 1, rows 0 and 2
    snap = rises;
    k0 = 4'd4; k1 = 4'd6; k0_on = 1'b1; k1_on = 1'b1;
    wait_valid(80, n);
    chk("p5_valid", valido, 1'b1);
    chk("p5_tecla", tecla, 4'd4);
    pulse_ack();
    repeat (40) tick();
    chk("p5_no_repeat", rises - snap, 1);
    k0_on = 1'b0; k1_on = 1'b0;
    repeat (30) tick();

    // 6. asynchronous reset during REPORT with the key still held
    k0 = 4'd9; k0_on = 1'b1;
    wait_valid(80, n);
    chk("p6_valid", valido, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("p6_rst_valid", valido, 1'b0);
    chk("p6_rst_cols", cols, 4'b1110);
    chk("p6_rst_tecla", tecla, 4'd0);
    repeat (3) tick();
    #2 rst_n = 1'b1;
    snap = rises;
    wait_valid(60, n);
    chk("p6_rereport", valido, 1'b1);
    chk("p6_latency", n, 20);
    chk("p6_tecla", tecla, 4'd9);
    tick();
    chk("p6_once", rises - snap, 1);
    pulse_ack();
    k0_on = 1'b0;
    repeat (30) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/escaner_teclado.md
Name: escaner_teclado

Overview:
Scanner for a 4x4 matrix keypad, the input-direction counterpart of the display ring decoder. It drives a one-hot active-low ring on the keypad columns and reads the row lines. It debounces one key at a time and presents a 4-bit key code with a valid/acknowledge handshake to the consumer logic. It sits at the board edge beside the display multiplexer and shares its ring-scan timing style.

Parameters:
SCAN_DIV, 1000, clocks per column window (minimum 2).
DEBOUNCE_COUNT, 3, consecutive identical samples needed to accept a press or a release (minimum 1).

Ports:
i_Clk  input  1  system clock; every register samples on its rising edge.
i_Reset  input  1  asynchronous, active-low reset.
i_Filas  input  4  keypad rows, active-low, externally pulled up, asynchronous to i_Clk.
o_Columnas  output  4  column drive, one-hot active-low.
o_Tecla  output  4  key code = column_index*4 + row_index.
o_Valido  output  1  key code is available; held until acknowledged.
i_Ack  input  1  consumer has taken o_Tecla; honoured only while o_Valido=1.

Behaviour:
- Reset values (asserted asynchronously while i_Reset=0): o_Columnas=4'b1110 (column 0), o_Tecla=0, o_Valido=0, state=SCAN, window counter=0, debounce counter=0, synchronizer flops=4'b1111.
- Row input: i_Filas passes through a two-flop synchronizer before any use.
- Window counter: runs 0..SCAN_DIV-1 and wraps. The sample point is the cycle where counter==SCAN_DIV-1, using the synchronized rows.
- Row decode at a sample:
  - "hit" = any synchronized row is 0.
  - row_index = lowest-numbered 0 bit; lower index wins when several rows are low.
  - Candidate code = current column*4 + row_index.
- State SCAN:
  - At each sample with no hit, rotate the ring 1110->1101->1011->0111->1110, advancing one column per window.
  - On a hit: latch the candidate code, set debounce counter=1, freeze the column, go to CONFIRM.
  - If DEBOUNCE_COUNT=1, go directly to REPORT.
- State CONFIRM (column frozen):
  - At each sample, a hit with the same code increments the counter. Reaching DEBOUNCE_COUNT goes to REPORT.
  - No hit or a different code: clear the counter, advance to the next column, return to SCAN.
- State REPORT:
  - o_Valido=1 from the first cycle in REPORT; o_Tecla holds the latched code, stable while valid.
  - In the cycle with i_Ack=1, o_Valido drops to 0 on the next edge and the state goes to RELEASE with counter=0.
  - A key released before the ack does not drop o_Valido; the event is never lost.
  - i_Ack while o_Valido=0 has no effect.
- State RELEASE (column frozen):
  - Each sample with no hit increments the counter; any hit clears it.
  - Counter reaching DEBOUNCE_COUNT: advance to the next column, return to SCAN.
  - A held key therefore never reports twice.
- Press latency (ideal contact, key on the currently driven column, asserted just after a sample):
  - 2 synchronizer cycles, then the first sample, then DEBOUNCE_COUNT-1 further windows before valid.
  - With SCAN_DIV=4 and DEBOUNCE_COUNT=3, o_Valido rises within 2+4*3+1 clocks.
- Multiple keys: only the first column in scan order with a hit, and its lowest row, is handled. Others are ignored until release completes.
- Reset mid-operation: immediate return to the reset values, including dropping o_Valido; any pending code is discarded.
- o_Tecla keeps its last value outside REPORT and is only meaningful while o_Valido=1.

Decomposition:
- Shared package teclado_pkg holds:
  - the state encoding: SCAN, CONFIRM, REPORT, RELEASE;
  - constants for the number of rows and columns (4) and the code width (4);
  - the idle column pattern 4'b1110.
- One natural sub-module: anillo_columnas, the window counter plus the 4-bit rotating active-low ring with a freeze input. It outputs the column index and the sample strobe.
- The FSM, synchronizer and row priority encoder stay in escaner_teclado.

Test Plan:
All scenarios use SCAN_DIV=4 and DEBOUNCE_COUNT=3 unless noted.
1. Reset: hold i_Reset=0 with arbitrary rows -> o_Columnas=1110, o_Valido=0, o_Tecla=0. Release with rows=1111 -> ring cycles 1110,1101,1011,0111,1110 every 4 clocks.
2. Clean press: model the keypad so row 1 reads 0 only while column 2 is driven (1011) -> o_Tecla=9, o_Valido=1 within 3 windows of the first hit. Ack with i_Ack=1 for one cycle -> o_Valido=0 next edge, column stays 1011 while the key is held. Release -> scanning resumes at 0111 after 3 idle samples.
3. Bounce: key at column 0 row 3 toggles on alternate windows -> no o_Valido. Then hold it stable -> o_Tecla=3 exactly once.
4. Late ack with early release: press column 3 row 0, release before ack -> o_Valido stays 1 with o_Tecla=12 until i_Ack, then no second report.
5. Two keys on one column: rows 0 and 2 low on column 1 -> o_Tecla=4. Held key gives no repeat after ack.
6. Reset mid-REPORT: assert i_Reset=0 asynchronously between edges -> o_Valido=0 and o_Columnas=1110 immediately. After release, the still-held key is reported once more after full debounce.
